// File: rtl/regfile_hazard_ctl.sv
// Register scoreboard and issue controller for the decode stage: per-register pending-write
// counters, RAW/WAW stall, flush drain. Optional macro HAZARD_WB_BYPASS_EN enables writeback bypass.
module regfile_hazard_ctl #(
  parameter int NREGS     = 16,
  parameter int CNT_W     = 2,
  parameter int DRAIN_CYC = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [63:0]                ir_i,
  input  logic                       valid_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [1:0]                 wb_en_i,
  input  logic [$clog2(NREGS)-1:0]   wb_addr_i,
  output logic                       stall_o,
  output logic                       issue_o,
  output logic [NREGS-1:0]           busy_o,
  output logic                       err_o
);

  // state    | meaning
  // ST_RUN   | normal operation, scoreboard tracks issues and writebacks
  // ST_DRAIN | after a flush, issue blocked while squashed ops leave the pipe

  localparam int IDX_W = $clog2(NREGS);
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [3:0] T_CMP   = 4'h3;
  localparam logic [3:0] T_MOV   = 4'h4;
  localparam logic [3:0] T_ALU   = 4'h9;
  localparam logic [3:0] T_LOAD  = 4'hb;
  localparam logic [3:0] T_STORE = 4'hc;
  localparam logic [3:0] T_LDI   = 4'hd;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DRN_W-1:0] r_drain;
  logic [DRN_W-1:0] w_drain_nxt;
  logic [CNT_W-1:0] r_cnt     [NREGS];
  logic [CNT_W-1:0] w_cnt_nxt [NREGS];
  logic             r_err;
  logic             w_err_nxt;

  logic [3:0]       w_type;
  logic [3:0]       w_op;
  logic [IDX_W-1:0] w_ra;
  logic [IDX_W-1:0] w_rb;
  logic [IDX_W-1:0] w_rc;
  logic [IDX_W-1:0] w_src1;
  logic [IDX_W-1:0] w_src2;
  logic [IDX_W-1:0] w_dest;
  logic             w_writer;
  logic             w_wb_act;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_hazard;
  logic             w_stall;
  logic             w_issue;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic             w_unused;

  assign w_type   = ir_i[31:28];
  assign w_op     = ir_i[27:24];
  assign w_ra     = ir_i[20 +: IDX_W];
  assign w_rb     = ir_i[16 +: IDX_W];
  assign w_rc     = ir_i[12 +: IDX_W];
  assign w_dest   = w_ra;
  assign w_unused = ^{ir_i[63:32], ir_i[11:0], w_op[3:2]};

  // Compare/store/load read ra,rb; everything else reads rb,rc. Both are always checked.
  always_comb begin
    w_src1 = w_rb;
    w_src2 = w_rc;
    if (w_type == T_CMP || w_type == T_STORE || w_type == T_LOAD) begin
      w_src1 = w_ra;
      w_src2 = w_rb;
    end
  end

  always_comb begin
    w_writer = 1'b0;
    case (w_type)
      T_LDI, T_LOAD, T_ALU: w_writer = 1'b1;
      T_MOV:                w_writer = (w_op[1:0] != 2'b00);
      default:              w_writer = 1'b0;
    endcase
  end

  assign w_wb_act = (wb_en_i != 2'b00) && (r_state == ST_RUN);

`ifdef HAZARD_WB_BYPASS_EN
  // The last outstanding write retiring now is visible through the register file write-through.
  assign w_raw1 = (r_cnt[w_src1] != '0) &&
                  !((r_cnt[w_src1] == CNT_W'(1)) && w_wb_act && (wb_addr_i == w_src1));
  assign w_raw2 = (r_cnt[w_src2] != '0) &&
                  !((r_cnt[w_src2] == CNT_W'(1)) && w_wb_act && (wb_addr_i == w_src2));
  assign w_waw  = w_writer && (r_cnt[w_dest] == CNT_MAX) &&
                  !(w_wb_act && (wb_addr_i == w_dest));
`else
  assign w_raw1 = (r_cnt[w_src1] != '0);
  assign w_raw2 = (r_cnt[w_src2] != '0);
  assign w_waw  = w_writer && (r_cnt[w_dest] == CNT_MAX);
`endif

  assign w_hazard = valid_i && (w_raw1 || w_raw2 || w_waw);
  assign w_stall  = w_hazard || stall_i || (r_state == ST_DRAIN);
  assign w_issue  = valid_i && !w_stall && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    case (r_state)
      ST_RUN: begin
        if (flush_i) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (flush_i) begin
          w_drain_nxt = DRN_LOAD;
        end else if (r_drain == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_drain_nxt = r_drain - DRN_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_drain_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue && w_writer) w_inc[w_dest] = 1'b1;
    if (w_wb_act)            w_dec[wb_addr_i] = 1'b1;
  end

  // Simultaneous inc/dec on one register cancels; a dec at zero saturates and flags an error.
  always_comb begin
    w_err_nxt = r_err;
    if (w_wb_act && (r_cnt[wb_addr_i] == '0)) w_err_nxt = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (flush_i) begin
        w_cnt_nxt[r] = '0;
      end else if (w_inc[r] && !w_dec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
      end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
        w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      r_err <= w_err_nxt;
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  always_comb begin
    busy_o = '0;
    for (int r = 0; r < NREGS; r++) busy_o[r] = (r_cnt[r] != '0);
  end

  assign stall_o = w_stall;
  assign issue_o = w_issue;
  assign err_o   = r_err;

endmodule

// File: tb/tb_regfile_hazard_ctl.sv
// Self-checking bench for regfile_hazard_ctl: directed vectors, per-cycle reference model compare.
module tb_regfile_hazard_ctl;

  localparam int NREGS     = 16;
  localparam int CNT_W     = 2;
  localparam int DRAIN_CYC = 3;
  localparam int MAXC      = (1 << CNT_W) - 1;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] T_INH   = 4'h0;
  localparam logic [3:0] T_CMP   = 4'h3;
  localparam logic [3:0] T_MOV   = 4'h4;
  localparam logic [3:0] T_ALU   = 4'h9;
  localparam logic [3:0] T_LOAD  = 4'hb;
  localparam logic [3:0] T_STORE = 4'hc;
  localparam logic [3:0] T_LDI   = 4'hd;

  logic             clk_i     = 1'b0;
  logic             rst_i     = 1'b0;
  logic [63:0]      ir_i      = '0;
  logic             valid_i   = 1'b0;
  logic             stall_i   = 1'b0;
  logic             flush_i   = 1'b0;
  logic [1:0]       wb_en_i   = '0;
  logic [3:0]       wb_addr_i = '0;
  logic             stall_o;
  logic             issue_o;
  logic [NREGS-1:0] busy_o;
  logic             err_o;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: outstanding writes per register, remaining drain cycles, sticky error
  int pend [NREGS];
  int drain_left;
  bit m_err;

  regfile_hazard_ctl #(.NREGS(NREGS), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .stall_o(stall_o), .issue_o(issue_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) pend[r] = 0;
    drain_left = 0;
    m_err = 1'b0;
  endtask

  function automatic bit src_blocked(input int s, input bit wb_now);
    if (pend[s] == 0) return 1'b0;
    if (BYP && pend[s] == 1 && wb_now && int'(wb_addr_i) == s) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_eval(output bit e_stall, output bit e_issue, output bit e_wr,
                            output bit e_wb);
    logic [3:0] t, ra, rb, rc;
    int s1, s2;
    bit haz;
    t  = ir_i[31:28];
    ra = ir_i[23:20];
    rb = ir_i[19:16];
    rc = ir_i[15:12];
    if (t == T_CMP || t == T_STORE || t == T_LOAD) begin
      s1 = int'(ra); s2 = int'(rb);
    end else begin
      s1 = int'(rb); s2 = int'(rc);
    end
    e_wr = (t == T_LDI) || (t == T_LOAD) || (t == T_ALU) || (t == T_MOV && ir_i[25:24] != 2'b00);
    e_wb = (wb_en_i != 2'b00) && (drain_left == 0);
    haz  = src_blocked(s1, e_wb) || src_blocked(s2, e_wb) ||
           (e_wr && pend[ra] == MAXC && !(BYP && e_wb && wb_addr_i == ra));
    e_stall = (valid_i && haz) || stall_i || (drain_left > 0);
    e_issue = valid_i && !e_stall && !flush_i;
  endtask

  always @(posedge clk_i or negedge rst_i) begin : model_upd
    bit es, ei, ew, eb;
    int d;
    if (!rst_i) begin
      model_reset();
    end else begin
      model_eval(es, ei, ew, eb);
      if (eb && pend[wb_addr_i] == 0) m_err = 1'b1;
      if (flush_i) begin
        for (int r = 0; r < NREGS; r++) pend[r] = 0;
        drain_left = DRAIN_CYC;
      end else begin
        if (drain_left > 0) drain_left--;
        d = int'(ir_i[23:20]);
        if (ei && ew) pend[d]++;
        if (eb && pend[wb_addr_i] > 0) pend[wb_addr_i]--;
      end
    end
  end

  always @(negedge clk_i) begin : compare
    bit es, ei, ew, eb;
    logic [NREGS-1:0] ebusy;
    model_eval(es, ei, ew, eb);
    for (int r = 0; r < NREGS; r++) ebusy[r] = (pend[r] > 0);
    chk("stall_o", 32'(stall_o), 32'(es));
    chk("issue_o", 32'(issue_o), 32'(ei));
    chk("busy_o",  32'(busy_o),  32'(ebusy));
    chk("err_o",   32'(err_o),   32'(m_err));
  end

  function automatic logic [63:0] mk(input logic [3:0] t, input logic [3:0] op,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [3:0] rc);
    logic [63:0] v;
    v = {32'hDEAD_BEEF, t, op, ra, rb, rc, 12'hABC};
    return v;
  endfunction

  task automatic drive(input logic [63:0] ir, input logic v, input logic s, input logic f,
                       input logic [1:0] we, input logic [3:0] wa);
    ir_i = ir; valid_i = v; stall_i = s; flush_i = f; wb_en_i = we; wb_addr_i = wa;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [63:0] nop;
  logic [63:0] rdr;

  initial begin
    model_reset();
    nop = mk(T_INH, 4'h0, 4'h0, 4'h0, 4'h0);

    // reset: outputs idle, combinational path live
    drive(nop, 1, 0, 0, 2'd0, 4'd0); #2;
    chk("lit_rst_busy", 32'(busy_o), 32'h0);
    chk("lit_rst_stall", 32'(stall_o), 32'h0);
    chk("lit_rst_issue", 32'(issue_o), 32'h1);
    chk("lit_rst_err", 32'(err_o), 32'h0);
    tick(); tick();
    rst_i = 1'b1;
    drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_idle_busy", 32'(busy_o), 32'h0);
    chk("lit_idle_stall", 32'(stall_o), 32'h0);
    tick();

    // downstream stall blocks issue
    drive(mk(T_ALU, 4'h0, 4'd1, 4'd0, 4'd0), 1, 1, 0, 2'd0, 4'd0); #1;
    chk("lit_stalli_stall", 32'(stall_o), 32'h1);
    chk("lit_stalli_issue", 32'(issue_o), 32'h0);
    tick();

    // RAW on r3
    drive(mk(T_ALU, 4'h0, 4'd3, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_raw_w_issue", 32'(issue_o), 32'h1);
    tick();
    rdr = mk(T_ALU, 4'h0, 4'd0, 4'd3, 4'd0);
    drive(rdr, 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_raw_busy", 32'(busy_o), 32'h0008);
    chk("lit_raw_stall", 32'(stall_o), 32'h1);
    tick();
    drive(rdr, 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_raw_stall2", 32'(stall_o), 32'h1);
    tick();
    drive(rdr, 1, 0, 0, 2'd3, 4'd3); #1;
`ifdef HAZARD_WB_BYPASS_EN
    chk("lit_raw_byp_issue", 32'(issue_o), 32'h1);
    tick();
`else
    chk("lit_raw_wb_stall", 32'(stall_o), 32'h1);
    tick();
    drive(rdr, 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_raw_rd_issue", 32'(issue_o), 32'h1);
    tick();
`endif
    drive(nop, 0, 0, 0, 2'd3, 4'd0); #1;
    chk("lit_raw_busy_r0", 32'(busy_o), 32'h0001);
    tick();
    drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_raw_busy_clr", 32'(busy_o), 32'h0);
    tick();

    // WAW saturation on r5
    for (int i = 0; i < 3; i++) begin
      drive(mk(T_LDI, 4'h0, 4'd5, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); #1;
      chk("lit_waw_issue", 32'(issue_o), 32'h1);
      tick();
    end
    drive(mk(T_LDI, 4'h0, 4'd5, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_waw_busy", 32'(busy_o), 32'h0020);
    chk("lit_waw_stall", 32'(stall_o), 32'h1);
    tick();
    drive(mk(T_LDI, 4'h0, 4'd5, 4'd0, 4'd0), 1, 0, 0, 2'd1, 4'd5); #1;
`ifdef HAZARD_WB_BYPASS_EN
    chk("lit_waw_byp_issue", 32'(issue_o), 32'h1);
    tick();
`else
    chk("lit_waw_wb_stall", 32'(stall_o), 32'h1);
    tick();
    drive(mk(T_LDI, 4'h0, 4'd5, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_waw_4th_issue", 32'(issue_o), 32'h1);
    tick();
`endif
    for (int i = 0; i < 3; i++) begin
      drive(nop, 0, 0, 0, 2'd2, 4'd5); #1;
      chk("lit_waw_still_busy", 32'(busy_o), 32'h0020);
      tick();
    end
    drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_waw_drained", 32'(busy_o), 32'h0);
    chk("lit_waw_err", 32'(err_o), 32'h0);
    tick();

    // load to r2 with writeback to r2 in flight
    drive(mk(T_LDI, 4'h0, 4'd2, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(mk(T_LOAD, 4'h0, 4'd2, 4'd0, 4'd0), 1, 0, 0, 2'd3, 4'd2); #1;
`ifdef HAZARD_WB_BYPASS_EN
    chk("lit_ld_byp_issue", 32'(issue_o), 32'h1);
    tick();
`else
    chk("lit_ld_stall", 32'(stall_o), 32'h1);
    tick();
    drive(mk(T_LOAD, 4'h0, 4'd2, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
`endif
    drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_ld_busy", 32'(busy_o), 32'h0004);
    tick();
    drive(nop, 0, 0, 0, 2'd3, 4'd2); tick();

    // issue and retire on the same register in one cycle
    drive(mk(T_LDI, 4'h0, 4'd6, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(mk(T_LDI, 4'h0, 4'd6, 4'd0, 4'd0), 1, 0, 0, 2'd3, 4'd6); #1;
    chk("lit_incdec_issue", 32'(issue_o), 32'h1);
    tick();
    drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_incdec_busy", 32'(busy_o), 32'h0040);
    tick();
    drive(nop, 0, 0, 0, 2'd3, 4'd6); tick();

    // MOV writer decode and STORE reading ra
    drive(mk(T_MOV, 4'h0, 4'd10, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_mov0_busy", 32'(busy_o), 32'h0);
    drive(mk(T_MOV, 4'h1, 4'd10, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(mk(T_STORE, 4'h0, 4'd10, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_mov1_busy", 32'(busy_o), 32'h0400);
    chk("lit_store_stall", 32'(stall_o), 32'h1);
    tick();
    drive(nop, 0, 0, 0, 2'd3, 4'd10); tick();

    // flush with stall, then a 3-cycle drain
    drive(mk(T_LDI, 4'h0, 4'd1, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(mk(T_LDI, 4'h0, 4'd7, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(mk(T_LDI, 4'h0, 4'd7, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); tick();
    drive(mk(T_ALU, 4'h0, 4'd8, 4'd0, 4'd0), 1, 1, 1, 2'd0, 4'd0); #1;
    chk("lit_fl_busy", 32'(busy_o), 32'h0082);
    chk("lit_fl_issue", 32'(issue_o), 32'h0);
    tick();
    for (int i = 0; i < DRAIN_CYC; i++) begin
      drive(mk(T_ALU, 4'h0, 4'd8, 4'd0, 4'd0), 1, 0, 0, (i == 0) ? 2'd3 : 2'd0, 4'd7); #1;
      chk("lit_dr_busy", 32'(busy_o), 32'h0);
      chk("lit_dr_stall", 32'(stall_o), 32'h1);
      chk("lit_dr_issue", 32'(issue_o), 32'h0);
      tick();
    end
    drive(mk(T_ALU, 4'h0, 4'd8, 4'd0, 4'd0), 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_dr_resume", 32'(issue_o), 32'h1);
    chk("lit_dr_err", 32'(err_o), 32'h0);
    tick();
    drive(nop, 0, 0, 0, 2'd3, 4'd8); tick();

    // flush during drain reloads the count
    drive(nop, 0, 0, 1, 2'd0, 4'd0); tick();
    drive(nop, 1, 0, 0, 2'd0, 4'd0); tick();
    drive(nop, 1, 0, 1, 2'd0, 4'd0); tick();
    for (int i = 0; i < DRAIN_CYC; i++) begin
      drive(nop, 1, 0, 0, 2'd0, 4'd0); #1;
      chk("lit_reload_stall", 32'(stall_o), 32'h1);
      tick();
    end
    drive(nop, 1, 0, 0, 2'd0, 4'd0); #1;
    chk("lit_reload_issue", 32'(issue_o), 32'h1);
    tick();

    // spurious writeback sets sticky error
    drive(nop, 0, 0, 0, 2'd3, 4'd9); #1;
    chk("lit_err_pre", 32'(err_o), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(nop, 0, 0, 0, 2'd0, 4'd0); #1;
      chk("lit_err_sticky", 32'(err_o), 32'h1);
      chk("lit_err_busy", 32'(busy_o), 32'h0);
      tick();
    end
    rst_i = 1'b0; #1;
    chk("lit_err_rst", 32'(err_o), 32'h0);
    tick();
    rst_i = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
